seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Multi-cycle signed integer divider (restoring, one quotient bit per cycle).
//   Inverse of the ALU add path: each iteration is a trial subtraction of the divisor.
//   Sits beside the ALU in the execute stage; the pipeline stalls on busy and
//   consumes the quotient/remainder when result_rdy pulses.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; two's-complement signed
// PORTS
//   clock       in   1      single clock; all state updates on rising edge
//   reset_n     in   1      synchronous reset, active-low
//   ctrl_div    in   1      start pulse; sampled only in IDLE
//   operand_a   in   WIDTH  dividend, sampled with ctrl_div
//   operand_b   in   WIDTH  divisor, sampled with ctrl_div
//   quotient    out  WIDTH  registered quotient; held until next start
//   remainder   out  WIDTH  registered remainder; held until next start
//   exception   out  1      divide-by-zero or signed overflow; held with results
//   result_rdy  out  1      one-cycle pulse: results valid
//   busy        out  1      high from the edge accepting a start until result_rdy pulses
// BEHAVIOUR
//   Reset (reset_n=0 at an edge): state=IDLE; quotient=0, remainder=0,
//     exception=0, result_rdy=0, busy=0, iteration count=0. Reset wins over all
//     other inputs, including mid-division; the in-flight result is discarded.
//   States: IDLE -> ITER -> FIX -> IDLE; IDLE -> FIX on an exception start.
//   IDLE: on edge E with ctrl_div=1, latch sign_q=a[msb]^b[msb], sign_r=a[msb],
//     |a| into the dividend shift register, |b| into the divisor register, partial
//     remainder=0, count=0; busy=1.
//     b==0 -> exception, go to FIX. a==MIN_INT and b==-1 -> exception, go to FIX.
//     Otherwise go to ITER.
//   ITER, one cycle per bit: pr' = {pr[WIDTH-2:0], dvd[msb]}; shift dvd left.
//     If pr' >= divisor (unsigned, WIDTH+1-bit subtract), pr = pr' - divisor and
//     shift in q bit 1; else pr = pr' and shift in q bit 0.
//     After WIDTH iterations (count==WIDTH-1 at the edge) go to FIX.
//   FIX, one cycle:
//     - Normal result: quotient = sign_q ? -q : q; remainder = sign_r ? -pr : pr
//       (truncating division; remainder takes the dividend's sign); exception=0.
//     - Exception result: quotient=0, remainder=0, exception=1.
//     - result_rdy=1 and busy=0 for the following cycle; state -> IDLE.
//   Latency, start sampled at edge E:
//     - Normal: result_rdy high in the cycle after edge E+WIDTH+1 (WIDTH+2 cycles).
//     - Exception: result_rdy high in the cycle after edge E+1 (2 cycles).
//   result_rdy is high for exactly one cycle and is 0 in every other state.
//   quotient, remainder and exception hold their last values until the next
//     FIX or reset.
//   ctrl_div while busy: ignored; operands are not re-sampled.
//   ctrl_div in the same cycle result_rdy is high: accepted, because the block is
//     already in IDLE. Back-to-back divisions therefore have no dead cycle.
//   Absolute value of MIN_INT: use the WIDTH-bit unsigned magnitude 2^(WIDTH-1);
//     the iteration is unsigned, so MIN_INT / 1 and MIN_INT / 2 are exact.
//   Negation in FIX is two's-complement WIDTH-bit. No result can overflow once
//     the MIN_INT/-1 case is excluded.
// TESTING
//   1. 100/7: start at E -> result_rdy after edge E+33; q=14, r=2, exception=0.
//   2. -100/7 -> q=-14, r=-2. 100/-7 -> q=-14, r=2.
//      -2147483648/2 -> q=-1073741824, r=0.
//   3. 5/0 -> result_rdy after edge E+1; q=0, r=0, exception=1.
//      -2147483648/-1 -> same response.
//   4. Start 100/7, pulse ctrl_div with 9/3 at E+5 -> ignored; q=14, r=2.
//      A start driven in the result_rdy cycle -> accepted; 9/3 gives q=3, r=0,
//      with result_rdy 34 cycles later.
//   5. Start 100/7, assert reset_n=0 at E+10 -> all outputs 0, busy=0.
//      A new 21/4 start -> q=5, r=1 at full latency.
//   6. Random signed pairs (b!=0, not MIN_INT/-1) vs reference a/b, a%b
//      (truncating); check busy and result_rdy timing on every transaction.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider, one quotient bit per cycle.
// Sits beside the ALU; busy stalls the pipe, result_rdy pulses once per division.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             exception,
    output logic             result_rdy,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] pr_q, pr_d;
    logic             sgnq_q, sgnq_d;
    logic             sgnr_q, sgnr_d;
    logic             exc_q, exc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             excout_q, excout_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             start_exc;
    logic [WIDTH:0]   pr_ext;
    logic [WIDTH:0]   diff;

    // Magnitude of MIN_INT wraps to 2^(WIDTH-1), which is correct as unsigned.
    assign abs_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign abs_b = operand_b[WIDTH-1] ? -operand_b : operand_b;

    assign start_exc = (operand_b == '0) ||
                       ((operand_a == MIN_INT) && (operand_b == '1));

    // pr stays below the divisor, so its top bit is always clear here.
    assign pr_ext = {pr_q, dvd_q[WIDTH-1]};
    assign diff   = pr_ext - {1'b0, dvs_q};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        pr_d     = pr_q;
        sgnq_d   = sgnq_q;
        sgnr_d   = sgnr_q;
        exc_d    = exc_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        excout_d = excout_q;
        rdy_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ctrl_div) begin
                    sgnq_d  = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    sgnr_d  = operand_a[WIDTH-1];
                    dvd_d   = abs_a;
                    dvs_d   = abs_b;
                    pr_d    = '0;
                    count_d = '0;
                    exc_d   = start_exc;
                    state_d = start_exc ? S_FIX : S_ITER;
                end
            end
            S_ITER: begin
                if (diff[WIDTH]) begin
                    pr_d = pr_ext[WIDTH-1:0];
                end else begin
                    pr_d = diff[WIDTH-1:0];
                end
                dvd_d   = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (exc_q) begin
                    quo_d    = '0;
                    rem_d    = '0;
                    excout_d = 1'b1;
                end else begin
                    quo_d    = sgnq_q ? -dvd_q : dvd_q;
                    rem_d    = sgnr_q ? -pr_q : pr_q;
                    excout_d = 1'b0;
                end
                rdy_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            pr_q     <= '0;
            sgnq_q   <= 1'b0;
            sgnr_q   <= 1'b0;
            exc_q    <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            excout_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            pr_q     <= pr_d;
            sgnq_q   <= sgnq_d;
            sgnr_q   <= sgnr_d;
            exc_q    <= exc_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            excout_q <= excout_d;
            rdy_q    <= rdy_d;
        end
    end

    assign quotient   = quo_q;
    assign remainder  = rem_q;
    assign exception  = excout_q;
    assign result_rdy = rdy_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: results, latency, busy, reset and
// start-handling corner cases, plus a short seeded random sweep.
module tb_seq_divider;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        exception;
    logic        result_rdy;
    logic        busy;

    int passed = 0;
    int total  = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ctrl_div   (ctrl_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .quotient   (quotient),
        .remainder  (remainder),
        .exception  (exception),
        .result_rdy (result_rdy),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Drive a start in the current cycle; returns at the negedge after its edge.
    task automatic fire(input logic [31:0] a, input logic [31:0] b);
        ctrl_div  = 1'b1;
        operand_a = a;
        operand_b = b;
        @(negedge clock);
        ctrl_div = 1'b0;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        fire(a, b);
    endtask

    // k = number of edges after the start edge when result_rdy is seen.
    task automatic wait_rdy(input int k0, output int k, output int bb);
        k  = k0;
        bb = 0;
        while (result_rdy !== 1'b1 && k < 60) begin
            if (busy !== 1'b1) bb++;
            @(negedge clock);
            k++;
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        ctrl_div  = 1'b1;
        operand_a = 32'd100;
        operand_b = 32'd7;
        repeat (3) @(negedge clock);
        total++; if (quotient !== 32'd0) $display("FAIL rst_q got %0d want 0", quotient); else passed++;
        total++; if (remainder !== 32'd0) $display("FAIL rst_r got %0d want 0", remainder); else passed++;
        total++; if (exception !== 1'b0) $display("FAIL rst_exc got %b want 0", exception); else passed++;
        total++; if (result_rdy !== 1'b0) $display("FAIL rst_rdy got %b want 0", result_rdy); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
        ctrl_div = 1'b0;
        reset_n  = 1'b1;
    endtask

    task automatic test_basic();
        int k, bb;
        launch(32'd100, 32'd7);
        total++; if (busy !== 1'b1) $display("FAIL basic_busy0 got %b want 1", busy); else passed++;
        wait_rdy(0, k, bb);
        total++; if (k !== 33) $display("FAIL basic_lat got %0d want 33", k); else passed++;
        total++; if (bb !== 0) $display("FAIL basic_busy got %0d low cycles want 0", bb); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_rdy got %b want 0", busy); else passed++;
        total++; if (quotient !== 32'd14) $display("FAIL basic_q got %0d want 14", $signed(quotient)); else passed++;
        total++; if (remainder !== 32'd2) $display("FAIL basic_r got %0d want 2", $signed(remainder)); else passed++;
        total++; if (exception !== 1'b0) $display("FAIL basic_exc got %b want 0", exception); else passed++;
        @(negedge clock);
        total++; if (result_rdy !== 1'b0) $display("FAIL basic_pulse got %b want 0", result_rdy); else passed++;
        total++; if (quotient !== 32'd14) $display("FAIL basic_hold got %0d want 14", $signed(quotient)); else passed++;
    endtask

    task automatic test_signs();
        logic [31:0] ta [4] = '{-32'sd100, 32'sd100, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb [4] = '{32'sd7, -32'sd7, 32'sd2, 32'sd1};
        logic [31:0] eq [4] = '{-32'sd14, -32'sd14, 32'hC000_0000, 32'h8000_0000};
        logic [31:0] er [4] = '{-32'sd2, 32'sd2, 32'sd0, 32'sd0};
        int k, bb;
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], tb[i]);
            wait_rdy(0, k, bb);
            total++; if (k !== 33) $display("FAIL sign%0d_lat got %0d want 33", i, k); else passed++;
            total++; if (quotient !== eq[i]) $display("FAIL sign%0d_q got %0d want %0d", i, $signed(quotient), $signed(eq[i])); else passed++;
            total++; if (remainder !== er[i]) $display("FAIL sign%0d_r got %0d want %0d", i, $signed(remainder), $signed(er[i])); else passed++;
            total++; if (exception !== 1'b0) $display("FAIL sign%0d_exc got %b want 0", i, exception); else passed++;
        end
    endtask

    task automatic test_exception();
        logic [31:0] ta [2] = '{32'd5, 32'h8000_0000};
        logic [31:0] tb [2] = '{32'd0, 32'hFFFF_FFFF};
        int k, bb;
        for (int i = 0; i < 2; i++) begin
            launch(ta[i], tb[i]);
            total++; if (busy !== 1'b1) $display("FAIL exc%0d_busy got %b want 1", i, busy); else passed++;
            wait_rdy(0, k, bb);
            total++; if (k !== 1) $display("FAIL exc%0d_lat got %0d want 1", i, k); else passed++;
            total++; if (quotient !== 32'd0) $display("FAIL exc%0d_q got %0d want 0", i, quotient); else passed++;
            total++; if (remainder !== 32'd0) $display("FAIL exc%0d_r got %0d want 0", i, remainder); else passed++;
            total++; if (exception !== 1'b1) $display("FAIL exc%0d_exc got %b want 1", i, exception); else passed++;
            @(negedge clock);
            total++; if (exception !== 1'b1) $display("FAIL exc%0d_hold got %b want 1", i, exception); else passed++;
        end
    endtask

    task automatic test_ignore_busy();
        int k, bb;
        launch(32'd100, 32'd7);
        repeat (4) @(negedge clock);
        fire(32'd9, 32'd3);
        wait_rdy(5, k, bb);
        total++; if (k !== 33) $display("FAIL ign_lat got %0d want 33", k); else passed++;
        total++; if (bb !== 0) $display("FAIL ign_busy got %0d low cycles want 0", bb); else passed++;
        total++; if (quotient !== 32'd14) $display("FAIL ign_q got %0d want 14", $signed(quotient)); else passed++;
        total++; if (remainder !== 32'd2) $display("FAIL ign_r got %0d want 2", $signed(remainder)); else passed++;
        @(negedge clock);
        total++; if (busy !== 1'b0) $display("FAIL ign_idle got %b want 0", busy); else passed++;
    endtask

    task automatic test_back_to_back();
        int k, bb;
        launch(32'd100, 32'd7);
        wait_rdy(0, k, bb);
        total++; if (quotient !== 32'd14) $display("FAIL b2b_q0 got %0d want 14", $signed(quotient)); else passed++;
        fire(32'd9, 32'd3);
        total++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy); else passed++;
        total++; if (quotient !== 32'd14) $display("FAIL b2b_hold got %0d want 14", $signed(quotient)); else passed++;
        wait_rdy(0, k, bb);
        total++; if (k !== 33) $display("FAIL b2b_lat got %0d want 33", k); else passed++;
        total++; if (quotient !== 32'd3) $display("FAIL b2b_q got %0d want 3", $signed(quotient)); else passed++;
        total++; if (remainder !== 32'd0) $display("FAIL b2b_r got %0d want 0", $signed(remainder)); else passed++;
    endtask

    task automatic test_reset_mid();
        int k, bb;
        launch(32'd100, 32'd7);
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        total++; if (quotient !== 32'd0) $display("FAIL rmid_q got %0d want 0", quotient); else passed++;
        total++; if (remainder !== 32'd0) $display("FAIL rmid_r got %0d want 0", remainder); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else passed++;
        total++; if (result_rdy !== 1'b0) $display("FAIL rmid_rdy got %b want 0", result_rdy); else passed++;
        reset_n = 1'b1;
        launch(32'd21, 32'd4);
        wait_rdy(0, k, bb);
        total++; if (k !== 33) $display("FAIL rmid_lat got %0d want 33", k); else passed++;
        total++; if (quotient !== 32'd5) $display("FAIL rmid_q2 got %0d want 5", $signed(quotient)); else passed++;
        total++; if (remainder !== 32'd1) $display("FAIL rmid_r2 got %0d want 1", $signed(remainder)); else passed++;
    endtask

    task automatic test_random();
        logic signed [31:0] a, b, eq, er;
        int k, bb;
        for (int i = 0; i < 8; i++) begin
            a = $signed($urandom);
            b = $signed(int'($urandom_range(0, 2000)) - 1000);
            if (b == 0) b = 32'sd3;
            if (a == 32'sh8000_0000 && b == -32'sd1) b = 32'sd5;
            eq = a / b;
            er = a % b;
            launch(a, b);
            wait_rdy(0, k, bb);
            total++; if (k !== 33 || bb !== 0) $display("FAIL rnd%0d_timing lat %0d busylow %0d want 33 0", i, k, bb); else passed++;
            total++; if (quotient !== eq) $display("FAIL rnd%0d_q %0d/%0d got %0d want %0d", i, a, b, $signed(quotient), eq); else passed++;
            total++; if (remainder !== er) $display("FAIL rnd%0d_r %0d%%%0d got %0d want %0d", i, a, b, $signed(remainder), er); else passed++;
            @(negedge clock);
            total++; if (result_rdy !== 1'b0) $display("FAIL rnd%0d_pulse got %b want 0", i, result_rdy); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_exception();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
